// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Fully pipelined add/subtract unit with block-level start/done/idle/ready
//   handshake. Accepts one operation per clock; a result appears PIPE_STAGES-1
//   edges after the accepting edge. Supports signed or unsigned operands,
//   wrap or saturate on overflow, and reports overflow/borrow alongside the
//   result.
//
// Parameters
//   DATA_WIDTH   operand/result width (2..64)
//   PIPE_STAGES  acceptance-to-result latency in clock edges (1..8)
//   SIGNED       1 = two's-complement operands, 0 = unsigned
//   SATURATE     1 = clamp on overflow, 0 = wrap modulo 2^DATA_WIDTH
//
// Ports
//   ap_clk    in   clock, rising edge
//   ap_rst    in   synchronous reset, active-high
//   ap_start  in   accept x/y/op on this edge
//   ap_ready  out  high whenever not in reset
//   ap_done   out  one-cycle pulse per completed operation
//   ap_idle   out  nothing in flight and no request pending
//   op        in   0 = x+y, 1 = x-y
//   x, y      in   operands
//   result    out  sum/difference, valid with ap_done, held otherwise
//   ovf       out  overflow/borrow flag, valid with ap_done, held otherwise

module pipelined_addsub #(
   parameter int DATA_WIDTH  = 32,
   parameter int PIPE_STAGES = 3,
   parameter int SIGNED      = 1,
   parameter int SATURATE    = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ap_start,
   output logic                  ap_ready,
   output logic                  ap_done,
   output logic                  ap_idle,
   input  logic                  op,
   input  logic [DATA_WIDTH-1:0] x,
   input  logic [DATA_WIDTH-1:0] y,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  ovf
);

   localparam int W  = DATA_WIDTH;
   localparam int NP = PIPE_STAGES;

   // vld[i] marks an operation accepted i edges ago; the top bit is ap_done.
   logic [NP-1:0] vld;
   logic          in_flight;

   // Returns {ovf, result}. The raw sum is formed one bit wider so the top
   // bit is the unsigned carry (add) or borrow (sub).
   function automatic logic [W:0] calc(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic         sub);
      logic [W:0]   raw;
      logic         ov;
      logic [W-1:0] res;
      raw = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      if (SIGNED != 0) begin
         // Subtraction overflows when A and ~B share a sign, i.e. A and B differ.
         if (sub)
            ov = (a[W-1] != b[W-1]) && (raw[W-1] != a[W-1]);
         else
            ov = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
      end else begin
         ov = raw[W];
      end
      res = raw[W-1:0];
      if ((SATURATE != 0) && ov) begin
         if (SIGNED != 0)
            // The sign of A gives the overflow direction in both add and sub.
            res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
         else
            res = sub ? '0 : '1;
      end
      return {ov, res};
   endfunction

   assign ap_ready = ~ap_rst;
   assign ap_done  = vld[NP-1];
   assign ap_idle  = ~ap_start & ~in_flight & ~ap_done;

   generate
      if (NP == 1) begin : g_single
         // Compute straight from the ports into the output register.
         assign in_flight = 1'b0;

         always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
               vld    <= '0;
               result <= '0;
               ovf    <= 1'b0;
            end else begin
               vld <= ap_start;
               if (ap_start)
                  {ovf, result} <= calc(x, y, op);
            end
         end
      end else begin : g_multi
         logic [W-1:0] s0_x;
         logic [W-1:0] s0_y;
         logic         s0_op;
         logic [W:0]   s0_calc;
         logic [W:0]   dpipe [1:NP-1];

         assign in_flight = |vld[NP-2:0];

         always_ff @(posedge ap_clk) begin
            if (ap_rst)
               vld <= '0;
            else
               vld <= {vld[NP-2:0], ap_start};
         end

         // Operand capture; gated so idle-cycle inputs never enter the datapath.
         always_ff @(posedge ap_clk) begin
            if (ap_start && !ap_rst) begin
               s0_x  <= x;
               s0_y  <= y;
               s0_op <= op;
            end
         end

         assign s0_calc = calc(s0_x, s0_y, s0_op);

         always_ff @(posedge ap_clk) begin
            if (ap_rst)
               dpipe[1] <= '0;
            else if (vld[0])
               dpipe[1] <= s0_calc;
         end

         // Each stage only moves on a valid bit, so the last stage holds
         // its value between completions.
         for (genvar g = 2; g < NP; g++) begin : g_stage
            always_ff @(posedge ap_clk) begin
               if (ap_rst)
                  dpipe[g] <= '0;
               else if (vld[g-1])
                  dpipe[g] <= dpipe[g-1];
            end
         end

         assign {ovf, result} = dpipe[NP-1];
      end
   endgenerate

endmodule
